ccip_mmio_csr_responder: RTL
============================

Name: ccip_mmio_csr_responder

Overview:
- AFU-side responder for host-initiated CCI-P MMIO requests.
- Decodes MMIO read and write requests arriving on Rx channel 0 and maintains a small 64-bit CSR file.
- Returns read responses on Tx channel 2, echoing the request tid.
- Sits between the FIU/emulator Rx/Tx buses and AFU control logic; it is the target for the MMIO traffic whose headers are t_ccip_Req_MmioHdr and t_ccip_Rsp_MmioHdr.

Parameters:
- MMIO_BASE, 16'h0000: base of CSR window, in 4B-address units; must be 2-aligned.
- NUM_CSR, 8: number of 64-bit CSRs, 2..64. Index 0 is the read-only DFH; indices 1..NUM_CSR-1 are read/write.
- DFH_VALUE, 64'h1000_0000_0000_0000: value returned for CSR index 0.

Ports:
- pClk  in  1  sole clock
- SoftReset  in  1  asynchronous, active-high reset
- rx_C0Hdr  in  28  MMIO request header overlaid on C0 header: [27:12] address (4B units), [11:10] length, [9] poison, [8:0] tid
- rx_C0Data  in  512  write data; only [63:0] is used
- rx_C0MmioRdValid  in  1  MMIO read request valid
- rx_C0MmioWrValid  in  1  MMIO write request valid
- tx_C2Hdr  out  9  response tid
- tx_C2MmioRdValid  out  1  read response valid, single-cycle pulse
- tx_C2Data  out  64  read response data
- csr_out  out  64*NUM_CSR  flat view of the CSR file; index i occupies bits [64i+63:64i]
- err_cnt  out  16  saturating count of rejected or erroneous requests

Behaviour:
- Reset (async assert, release synchronous to pClk):
  - tx_C2MmioRdValid=0, tx_C2Hdr=0, tx_C2Data=0, err_cnt=0.
  - CSRs 1..NUM_CSR-1 = 0; CSR0 always reads DFH_VALUE.
  - Pipeline valids cleared. Requests in flight at reset are discarded with no response.
- Decode:
  - off = address - MMIO_BASE, 16-bit modulo arithmetic.
  - idx = off[15:1], half = off[0].
  - In-range: off < 2*NUM_CSR, i.e. the unsigned compare rejects underflow wrap-around.
- Length handling:
  - 2'b00 (4B): half selects bits [31:0] (half=0) or [63:32] (half=1).
  - 2'b01 (8B): requires half=0, otherwise misaligned.
  - 2'b10 and 2'b11 (64B/reserved): unsupported.
- Write, cycle T with rx_C0MmioWrValid=1: commits at the pClk edge ending T. Legal write (in-range, idx!=0, supported length, aligned, poison=0):
  - 8B write updates all 64 bits.
  - 4B write updates only the selected 32-bit half from rx_C0Data[31:0].
- Dropped writes: any other write is dropped and err_cnt increments. Exceptions:
  - Write to idx 0 is silently ignored, with no error.
  - Poisoned writes are dropped and counted.
- Read, cycle T with rx_C0MmioRdValid=1:
  - Stage 1: the header is registered at the edge ending T.
  - Stage 2: data is selected from the current CSR contents and registered at the edge ending T+1.
  - Outputs: tx_C2MmioRdValid=1 and tx_C2Hdr=tid during cycle T+2. Fixed 2-cycle latency.
- Read data:
  - 8B read returns the full CSR.
  - 4B read returns the selected half in both [31:0] and [63:32].
- Erroneous reads still respond, since the host must never hang:
  - out-of-range, misaligned, unsupported length or poisoned reads return 64'h0 with the echoed tid, and err_cnt increments.
- Read-after-write: a write in cycle T followed by a read of the same CSR in cycle T+1 returns the new value, because stage-2 selection happens after the write commits.
- Throughput and ordering:
  - One request per cycle; back-to-back reads produce back-to-back responses in request order.
  - No backpressure exists on C2.
- Both valids high in the same cycle is a protocol violation:
  - the write is processed, the read is discarded with no response, and err_cnt increments by 1.
- err_cnt:
  - saturates at 16'hFFFF;
  - at most +1 per cycle.

Test Plan:
- Reset, then 8B read of address MMIO_BASE with tid=9'h05 -> tx_C2MmioRdValid pulses exactly 2 cycles later; tx_C2Hdr=9'h05; tx_C2Data=DFH_VALUE; err_cnt=0.
- 8B write of 64'hDEAD_BEEF_0123_4567 to idx 1 (address 16'h0002), then 4B read of address 16'h0003 -> data 64'hDEAD_BEEF_DEAD_BEEF; csr_out[127:64] matches the written value.
- 4B write of 32'hA5A5_A5A5 to address 16'h0004 (idx 2, low half) over a prior 64'hFFFF_FFFF_FFFF_FFFF -> CSR2 = 64'hFFFF_FFFF_A5A5_A5A5. A read issued the very next cycle returns that value.
- Four back-to-back 8B reads of idx 0..3 with tids 1..4 -> four consecutive response cycles, tids 1,2,3,4 in order, no gaps.
- Error cases -> err_cnt ends at 5; each read still responds with data 0; CSR file unchanged:
  - read of address 16'h0010 with NUM_CSR=8 (out-of-range);
  - 8B read of address 16'h0003 (misaligned);
  - poisoned write to idx 1;
  - 64B write to idx 2;
  - simultaneous read+write valids.
- Assert SoftReset asynchronously one cycle after a read request -> no response pulse; all CSRs read 0 except CSR0 = DFH_VALUE; err_cnt=0.

Source files
------------

// File: rtl/ccip_mmio_csr_responder.sv
// CCI-P MMIO responder: decodes host MMIO reads/writes on C0 and keeps a
// small 64-bit CSR file. Index 0 is a read-only DFH. Reads answer on C2
// with a fixed two-cycle latency, and erroneous reads still answer with zero.
module ccip_mmio_csr_responder #(
  parameter logic [15:0] MMIO_BASE = 16'h0000,
  parameter int unsigned NUM_CSR   = 8,
  parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000
) (
  input  logic                    pClk,
  input  logic                    SoftReset,
  input  logic [27:0]             rx_C0Hdr,
  input  logic [511:0]            rx_C0Data,
  input  logic                    rx_C0MmioRdValid,
  input  logic                    rx_C0MmioWrValid,
  output logic [8:0]              tx_C2Hdr,
  output logic                    tx_C2MmioRdValid,
  output logic [63:0]             tx_C2Data,
  output logic [64*NUM_CSR-1:0]   csr_out,
  output logic [15:0]             err_cnt
);

  // Request decode
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic        req_poison;
  logic [8:0]  req_tid;
  logic [15:0] req_off;
  logic [14:0] req_idx;
  logic        req_half;
  logic        req_in_range;
  logic        req_ok;
  logic        unused_data;

  assign req_addr     = rx_C0Hdr[27:12];
  assign req_len      = rx_C0Hdr[11:10];
  assign req_poison   = rx_C0Hdr[9];
  assign req_tid      = rx_C0Hdr[8:0];
  assign req_off      = req_addr - MMIO_BASE;
  assign req_idx      = req_off[15:1];
  assign req_half     = req_off[0];
  // Unsigned compare also rejects addresses below the base (wrapped offset).
  assign req_in_range = 32'(req_off) < (2 * NUM_CSR);
  assign req_ok       = req_in_range && !req_poison &&
                        ((req_len == 2'b00) || (req_len == 2'b01 && !req_half));
  assign unused_data  = ^rx_C0Data[511:64];

  // State
  logic [NUM_CSR-1:1][63:0] csr_q, csr_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_inc;
  logic        s1_valid_q, s1_valid_d;
  logic [8:0]  s1_tid_q, s1_tid_d;
  logic [14:0] s1_idx_q, s1_idx_d;
  logic        s1_half_q, s1_half_d;
  logic        s1_len8_q, s1_len8_d;
  logic        s1_ok_q, s1_ok_d;
  logic        tx_valid_q, tx_valid_d;
  logic [8:0]  tx_hdr_q, tx_hdr_d;
  logic [63:0] tx_data_q, tx_data_d;
  logic [63:0] rd_word;

  assign csr_out          = {csr_q, DFH_VALUE};
  assign err_cnt          = err_cnt_q;
  assign tx_C2MmioRdValid = tx_valid_q;
  assign tx_C2Hdr         = tx_hdr_q;
  assign tx_C2Data        = tx_data_q;

  // Write commit and saturating error counter (at most +1 per cycle)
  always_comb begin
    csr_d     = csr_q;
    err_cnt_d = err_cnt_q;
    err_inc   = 1'b0;
    if (rx_C0MmioWrValid) begin
      // Legal writes to index 0 fall through the loop: ignored, no error.
      if (!req_ok || rx_C0MmioRdValid) begin
        err_inc = 1'b1;
      end
      if (req_ok) begin
        for (int unsigned i = 1; i < NUM_CSR; i++) begin
          if (32'(req_idx) == i) begin
            if (req_len == 2'b01) begin
              csr_d[i] = rx_C0Data[63:0];
            end else if (req_half) begin
              csr_d[i][63:32] = rx_C0Data[31:0];
            end else begin
              csr_d[i][31:0] = rx_C0Data[31:0];
            end
          end
        end
      end
    end else if (rx_C0MmioRdValid && !req_ok) begin
      err_inc = 1'b1;
    end
    if (err_inc && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Read stage 1: capture decoded header; a read alongside a write is dropped
  always_comb begin
    s1_valid_d = rx_C0MmioRdValid && !rx_C0MmioWrValid;
    s1_tid_d   = req_tid;
    s1_idx_d   = req_idx;
    s1_half_d  = req_half;
    s1_len8_d  = (req_len == 2'b01);
    s1_ok_d    = req_ok;
  end

  // Read stage 2: select from CSRs as they stand after any write committed at the previous edge
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_CSR; i++) begin
      if (32'(s1_idx_q) == i) begin
        rd_word = csr_out[64*i +: 64];
      end
    end
    tx_valid_d = s1_valid_q;
    tx_hdr_d   = tx_hdr_q;
    tx_data_d  = tx_data_q;
    if (s1_valid_q) begin
      tx_hdr_d = s1_tid_q;
      if (!s1_ok_q) begin
        tx_data_d = '0;
      end else if (s1_len8_q) begin
        tx_data_d = rd_word;
      end else if (s1_half_q) begin
        tx_data_d = {rd_word[63:32], rd_word[63:32]};
      end else begin
        tx_data_d = {rd_word[31:0], rd_word[31:0]};
      end
    end
  end

  // State registers
  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      csr_q      <= '0;
      err_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_tid_q   <= '0;
      s1_idx_q   <= '0;
      s1_half_q  <= 1'b0;
      s1_len8_q  <= 1'b0;
      s1_ok_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_hdr_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      csr_q      <= csr_d;
      err_cnt_q  <= err_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_tid_q   <= s1_tid_d;
      s1_idx_q   <= s1_idx_d;
      s1_half_q  <= s1_half_d;
      s1_len8_q  <= s1_len8_d;
      s1_ok_q    <= s1_ok_d;
      tx_valid_q <= tx_valid_d;
      tx_hdr_q   <= tx_hdr_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule
